// File: rtl/alu_pkg.sv
// Shared ALU operation codes, used by the ALU control decoder and by alu_exec.
package alu_pkg;

    localparam logic [3:0] AND   = 4'b0000;
    localparam logic [3:0] OR    = 4'b0001;
    localparam logic [3:0] ADD   = 4'b0010;
    localparam logic [3:0] SUB   = 4'b0110;
    localparam logic [3:0] SLT   = 4'b0111;
    localparam logic [3:0] UNDEF = 4'b1111;

    localparam int ERR_W = 8;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op inside {AND, OR, ADD, SUB, SLT};
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operation-in / result-out handshake bundle for alu_exec.
interface alu_exec_if
    import alu_pkg::*;
#(
    parameter int XLEN = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         operation;
    logic [XLEN-1:0]    src_a;
    logic [XLEN-1:0]    src_b;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    result;
    logic               zero;
    logic               illegal;
    logic [ERR_W-1:0]   err_cnt;

    // master: upstream producer plus downstream consumer; slave: alu_exec
    modport master (
        output in_valid, operation, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal, err_cnt
    );

    modport slave (
        input  in_valid, operation, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal, err_cnt
    );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath; undefined codes yield result 0 and illegal.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      operation,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    always_comb begin
        result  = '0;
        illegal = !op_is_legal(operation);
        // add/sub wrap modulo 2^XLEN; carry and overflow are simply dropped
        case (operation)
            ADD:     result = a + b;
            SUB:     result = a - b;
            AND:     result = a & b;
            OR:      result = a | b;
            SLT:     result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: computes on acceptance and queues results in a small
// in-order buffer, plus a saturating counter of accepted illegal operations.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2     // only 2 is supported
) (
    input  logic    clk,
    input  logic    rst_n,
    alu_exec_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [XLEN-1:0]    core_result;
    logic               core_illegal;

    logic [XLEN-1:0]    entry_result  [DEPTH];
    logic               entry_zero    [DEPTH];
    logic               entry_illegal [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               ready_en_reg;
    logic [ERR_W-1:0]   err_cnt_reg;

    logic               push;
    logic               pop;

    alu_core #(
        .XLEN (XLEN)
    ) u_core (
        .operation (bus.operation),
        .a         (bus.src_a),
        .b         (bus.src_b),
        .result    (core_result),
        .illegal   (core_illegal)
    );

    // ready_en_reg keeps in_ready low while reset is held and until the first edge after it
    assign bus.in_ready  = ready_en_reg && (count_reg != FULL);
    assign bus.out_valid = (count_reg != '0);
    assign bus.result    = entry_result[rd_ptr_reg];
    assign bus.zero      = entry_zero[rd_ptr_reg];
    assign bus.illegal   = entry_illegal[rd_ptr_reg];
    assign bus.err_cnt   = err_cnt_reg;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Entries are cleared on reset so the head outputs read 0 rather than stale data.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [XLEN-1:0] result_reg;
            logic            zero_reg;
            logic            illegal_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    result_reg  <= '0;
                    zero_reg    <= 1'b0;
                    illegal_reg <= 1'b0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    result_reg  <= core_result;
                    zero_reg    <= (core_result == '0);
                    illegal_reg <= core_illegal;
                end
            end

            assign entry_result[gi]  = result_reg;
            assign entry_zero[gi]    = zero_reg;
            assign entry_illegal[gi] = illegal_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            ready_en_reg <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            count_reg    <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && core_illegal && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec: arithmetic corners, back-pressure,
// streaming, illegal-op counter saturation and mid-operation reset.
module tb_alu_exec;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   failed;

    alu_exec_if #(.XLEN(32)) bus ();

    alu_exec #(
        .XLEN  (32),
        .DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid  = 1'b1;
        bus.operation = op;
        bus.src_a     = a;
        bus.src_b     = b;
    endtask

    // Push one op into an empty buffer with out_ready 1, check head, then confirm the pop.
    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_zero, input logic exp_ill);
        drive(op, a, b);
        cyc();
        bus.in_valid = 1'b0;
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".result"},    bus.result,          exp_res);
        check({tag, ".zero"},      32'(bus.zero),       32'(exp_zero));
        check({tag, ".illegal"},   32'(bus.illegal),    32'(exp_ill));
        $display("op=%b a=%h b=%h -> result=%h zero=%b illegal=%b", op, a, b,
                 bus.result, bus.zero, bus.illegal);
        cyc();
        check({tag, ".popped"},    32'(bus.out_valid),  32'd0);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.operation = 4'b0000;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #3;
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.in_ready",  32'(bus.in_ready),  32'd0);
        check("rst.err_cnt",   32'(bus.err_cnt),   32'd0);
        check("rst.result",    bus.result,         32'd0);
        check("rst.zero",      32'(bus.zero),      32'd0);
        check("rst.illegal",   32'(bus.illegal),   32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();
        check("post_rst.in_ready",  32'(bus.in_ready),  32'd1);
        check("post_rst.out_valid", 32'(bus.out_valid), 32'd0);

        // Arithmetic corners, one op at a time
        bus.out_ready = 1'b1;
        single("add_ovf",   ADD,     32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0);
        single("sub_eq",    SUB,     32'd5,         32'd5,         32'h0000_0000, 1'b1, 1'b0);
        single("sub_wrap",  SUB,     32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0);
        single("slt_neg",   SLT,     32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0);
        single("slt_pos",   SLT,     32'd1,         32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0);
        single("undef0100", 4'b0100, 32'd3,         32'd3,         32'd0,         1'b1, 1'b1);
        check("err_cnt_one", 32'(bus.err_cnt), 32'd1);

        // Back-pressure: three ops back to back with out_ready low
        bus.out_ready = 1'b0;
        drive(AND, 32'h0000_F0F0, 32'h0000_FF00);
        cyc();
        check("bp.in_ready_after1", 32'(bus.in_ready), 32'd1);
        drive(OR, 32'h0000_F0F0, 32'h0000_0F0F);
        cyc();
        check("bp.in_ready_after2", 32'(bus.in_ready), 32'd0);
        drive(ADD, 32'd3, 32'd4);
        cyc();
        check("bp.held_in_ready", 32'(bus.in_ready),  32'd0);
        check("bp.held_valid",    32'(bus.out_valid), 32'd1);
        check("bp.held_result",   bus.result,         32'h0000_F000);
        bus.out_ready = 1'b1;
        cyc();
        $display("bp pop1 result=%h", bus.result);
        check("bp.second_head", bus.result,        32'h0000_FFFF);
        check("bp.in_ready_re", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_valid = 1'b0;
        $display("bp pop2 result=%h", bus.result);
        check("bp.third_head",  bus.result,         32'd7);
        check("bp.third_valid", 32'(bus.out_valid), 32'd1);
        cyc();
        check("bp.drained", 32'(bus.out_valid), 32'd0);

        // Streaming at count 1: push and pop on every edge
        for (int i = 0; i <= 10; i++) begin
            drive(ADD, 32'(i), 32'(2 * i));
            cyc();
            $display("stream i=%0d result=%0d", i, bus.result);
            check("stream.result",    bus.result,         32'(3 * i));
            check("stream.out_valid", 32'(bus.out_valid), 32'd1);
            check("stream.in_ready",  32'(bus.in_ready),  32'd1);
        end
        bus.in_valid = 1'b0;
        cyc();
        check("stream.drained", 32'(bus.out_valid), 32'd0);

        // 300 illegal ops: counter saturates at 255
        for (int i = 1; i <= 300; i++) begin
            drive(UNDEF, 32'(i), 32'(i * 7));
            cyc();
            check("undef.illegal", 32'(bus.illegal), 32'd1);
            check("undef.result",  bus.result,       32'd0);
            check("undef.zero",    32'(bus.zero),    32'd1);
            if (i == 100) begin
                check("undef.err_cnt_101", 32'(bus.err_cnt), 32'd101);
            end
        end
        bus.in_valid = 1'b0;
        $display("undef burst err_cnt=%0d", bus.err_cnt);
        check("undef.err_cnt_sat", 32'(bus.err_cnt), 32'd255);
        cyc();
        check("undef.drained", 32'(bus.out_valid), 32'd0);

        // Reset with two entries buffered
        bus.out_ready = 1'b0;
        drive(ADD, 32'd1, 32'd1);
        cyc();
        drive(ADD, 32'd2, 32'd2);
        cyc();
        bus.in_valid = 1'b0;
        check("mid.full_valid",    32'(bus.out_valid), 32'd1);
        check("mid.full_in_ready", 32'(bus.in_ready),  32'd0);
        check("mid.head",          bus.result,         32'd2);
        #2 rst_n = 1'b0;
        #1;
        $display("mid reset out_valid=%b err_cnt=%0d", bus.out_valid, bus.err_cnt);
        check("mid.rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid.rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("mid.rst_err_cnt",   32'(bus.err_cnt),   32'd0);
        check("mid.rst_result",    bus.result,         32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();
        check("mid.rel_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid.rel_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        cyc();
        check("mid.no_reappear", 32'(bus.out_valid), 32'd0);
        single("post_mid_add", ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width in bits.
REQ-002 SHALL have parameter DEPTH, fixed at 2, number of result buffer entries; other values are not supported.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream holds a valid operation this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts an operation this cycle.
REQ-007 SHALL have port operation  input  4  ALU control code from the ALU control decoder.
REQ-008 SHALL have port src_a  input  XLEN  first operand.
REQ-009 SHALL have port src_b  input  XLEN  second operand.
REQ-010 SHALL have port out_valid  output  1  head buffer entry is valid.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the head entry this cycle.
REQ-012 SHALL have port result  output  XLEN  head entry result.
REQ-013 SHALL have port zero  output  1  head entry result equals 0.
REQ-014 SHALL have port illegal  output  1  head entry was produced by an undefined operation code.
REQ-015 SHALL have port err_cnt  output  8  saturating count of accepted illegal operations.

Function
REQ-016 SHALL map the operation codes as follows: 0010 add; 0110 subtract (a-b); 0000 bitwise AND; 0001 bitwise OR; 0111 signed set-less-than (result 1 or 0, zero-extended).
REQ-017 SHALL treat every other code, 1111 included, as illegal, with result 0, zero 1 and illegal 1.
REQ-018 SHALL discard carry and overflow so that add and subtract wrap modulo 2^XLEN.
REQ-019 SHALL accept an operation when in_valid and in_ready are both 1 at a rising edge.
REQ-020 SHALL store the computed result, zero and illegal for an accepted operation in the buffer at that edge.
REQ-021 SHALL present an operation accepted at edge N on the outputs from cycle N+1 when the buffer was empty, giving a latency of 1 cycle.
REQ-022 SHALL drive in_ready as (count != 2), with count the registered occupancy 0..2 and no combinational path from out_ready.
REQ-023 SHALL drive out_valid as (count != 0), with result, zero and illegal always taken from the head entry.
REQ-024 SHALL pop the head entry when out_valid and out_ready are both 1 at a rising edge.
REQ-025 SHALL hold result, zero and illegal stable while out_valid is 1 and out_ready is 0.
REQ-026 SHALL leave count unchanged on a simultaneous push and pop at count 1, with the new entry becoming head on the next cycle.
REQ-027 SHALL, on a push at count 0 or 1 without a pop, increment count.
REQ-028 SHALL, on a pop without a push, decrement count.
REQ-029 SHALL, at count 2, not push (in_ready is 0); a pop decrements count to 1.
REQ-030 SHALL deliver results in acceptance order.
REQ-031 SHALL ignore operation, src_a and src_b when no operation is accepted, i.e. whenever in_valid or in_ready is 0.
REQ-032 SHALL increment err_cnt on every accepted illegal operation and saturate it at 255.

Reset
REQ-033 SHALL, while rst_n is 0, asynchronously force count to 0, out_valid to 0, in_ready to 0, err_cnt to 0, result to 0, zero to 0 and illegal to 0.
REQ-034 SHALL make in_ready 1 from the first cycle after rst_n deasserts.
REQ-035 SHALL drop any buffered entries when reset is asserted mid-operation, and none of them reappears after reset.

Structure
REQ-036 SHALL take the operation-code constants (ADD, SUB, AND, OR, SLT, UNDEF) from a shared package alu_pkg used by the ALU control decoder and alu_exec.
REQ-037 SHALL place the combinational compute in the sub-module alu_core, with inputs operation, a and b and outputs result and illegal.
REQ-038 SHALL keep the buffer, count and err_cnt in alu_exec.

Verification
REQ-039 SHALL cover: add 0x7FFFFFFF+1 with out_ready 1 -> result 0x80000000, zero 0, out_valid high one cycle after acceptance.
REQ-040 SHALL cover: sub 5-5 -> result 0, zero 1; slt a=0xFFFFFFFF (-1), b=1 -> result 1; slt a=1, b=0xFFFFFFFF -> result 0.
REQ-041 SHALL cover: out_ready 0 while pushing three ops (and, or, add) back to back -> in_ready 0 after the second; the third is held upstream and accepted after the first pop; outputs appear in order.
REQ-042 SHALL cover: simultaneous push and pop at count 1 over 10 cycles -> count stays 1, all 10 results delivered in order, no loss.
REQ-043 SHALL cover: 300 accepted ops with code 1111 -> each output illegal 1 with result 0; err_cnt reads 255.
REQ-044 SHALL cover: rst_n pulsed low with 2 entries buffered -> out_valid 0 immediately, err_cnt 0, in_ready 1 on the first cycle after release.
